// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
package uart_pkg;

    localparam logic        UART_IDLE_LVL  = 1'b1;
    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } uart_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit.
module sync_ff #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receiver: mid-bit sampling of an 8-bit frame with optional even parity and break handling.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic [31:0] clk_div_i,
    input  logic        rx_enable_i,
    input  logic        parity_en_i,
    input  logic        rx_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic        rx_err_o,
    output logic        frame_err_o
);

    uart_state_e state_q, state_d;

    logic [31:0]               cnt_q, cnt_d;
    logic [31:0]               div_q, div_d;
    logic                      par_en_q, par_en_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      par_err_q, par_err_d;
    logic [7:0]                data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      err_q, err_d;
    logic                      ferr_q, ferr_d;

    logic        rx_sync;
    logic        expire;
    logic        line_low;
    logic [31:0] div_sel;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (UART_IDLE_LVL)
    ) u_sync (
        .clk    (clk),
        .rstn_i (rstn_i),
        .d_i    (rx_i),
        .q_o    (rx_sync)
    );

    assign div_sel  = (clk_div_i < 32'd2) ? 32'd2 : clk_div_i;
    assign expire   = (cnt_q == 32'd1);
    assign line_low = (rx_sync != UART_IDLE_LVL);

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q > 32'd1) ? cnt_q - 32'd1 : cnt_q;
        div_d     = div_q;
        par_en_d  = par_en_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = err_q;
        ferr_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (rx_enable_i && line_low) begin
                    div_d     = div_sel;
                    par_en_d  = parity_en_i;
                    cnt_d     = div_sel >> 1;
                    bit_cnt_d = 3'd0;
                    par_err_d = 1'b0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (expire) begin
                    if (line_low) begin
                        cnt_d   = div_q;
                        state_d = StData;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (expire) begin
                    shift_d   = {rx_sync, shift_q[UART_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    cnt_d     = div_q;
                    if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) begin
                        state_d = par_en_q ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (expire) begin
                    par_err_d = (^shift_q) ^ rx_sync;
                    cnt_d     = div_q;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (expire) begin
                    if (!line_low) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                        err_d   = par_en_q & par_err_q;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end
            end
            StBreak: begin
                if (!line_low) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Disabling abandons the frame without publishing anything from it.
        if (!rx_enable_i) begin
            state_d = StIdle;
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            data_d  = data_q;
            err_d   = err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            state_q   <= StIdle;
            cnt_q     <= 32'd0;
            div_q     <= 32'd0;
            par_en_q  <= 1'b0;
            bit_cnt_q <= 3'd0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            par_en_q  <= par_en_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            ferr_q    <= ferr_d;
        end
    end

    assign rx_data_o   = data_q;
    assign rx_valid_o  = valid_q;
    assign rx_err_o    = err_q;
    assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Randomized and directed bench for uart_rx_sampler against a frame-level timing model.
module tb_uart_rx_sampler;

    localparam int S = 2;

    logic        clk;
    logic        rstn_i;
    logic [31:0] clk_div_i;
    logic        rx_enable_i;
    logic        parity_en_i;
    logic        rx_i;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_err_o;
    logic        frame_err_o;

    uart_rx_sampler #(
        .SYNC_STAGES (S)
    ) dut (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .clk_div_i   (clk_div_i),
        .rx_enable_i (rx_enable_i),
        .parity_en_i (parity_en_i),
        .rx_i        (rx_i),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_err_o    (rx_err_o),
        .frame_err_o (frame_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Expected events keyed by the cycle whose following negedge shows them: 1 = byte, 2 = frame error.
    int       exp_kind[int];
    bit [7:0] exp_data[int];
    bit       exp_err[int];

    bit       rst_edge = 1'b0;
    bit       started  = 1'b0;
    bit [7:0] model_data = 8'h00;
    bit       model_err  = 1'b0;

    int       n_valid = 0;
    int       n_ferr  = 0;
    int       last_v_cyc = -1;
    int       last_f_cyc = -1;
    logic [7:0] last_v_data;
    logic     last_v_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= !rstn_i;
    end

    always @(negedge clk) begin
        int kind;
        if (rst_edge) begin
            started    = 1'b1;
            model_data = 8'h00;
            model_err  = 1'b0;
        end
        if (started) begin
            kind = (!rst_edge && exp_kind.exists(cyc)) ? exp_kind[cyc] : 0;
            if (kind == 1) begin
                model_data = exp_data[cyc];
                model_err  = exp_err[cyc];
            end
            chk("rx_valid_o",  32'(rx_valid_o),  32'(kind == 1));
            chk("frame_err_o", 32'(frame_err_o), 32'(kind == 2));
            chk("rx_data_o",   32'(rx_data_o),   32'(model_data));
            chk("rx_err_o",    32'(rx_err_o),    32'(model_err));
            if (rx_valid_o === 1'b1) begin
                n_valid++;
                last_v_cyc  = cyc;
                last_v_data = rx_data_o;
                last_v_err  = rx_err_o;
            end
            if (frame_err_o === 1'b1) begin
                n_ferr++;
                last_f_cyc = cyc;
            end
        end
    end

    task automatic drive(input bit v, input int len);
        rx_i = v;
        repeat (len) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Transmits one frame; when expect_out is set, schedules the receiver's pulse at the stop mid-point + 1.
    task automatic send_frame(input bit [7:0] d, input int div, input bit pen, input bit pbit,
                              input bit stop, input int stop_len, input bit expect_out,
                              input bit scramble, output int n0);
        int de;
        int ks;
        de          = (div < 2) ? 2 : div;
        clk_div_i   = 32'(div);
        parity_en_i = pen;
        n0          = cyc;
        if (expect_out) begin
            ks = n0 + S + 1 + de / 2 + (9 + int'(pen)) * de;
            if (stop) begin
                exp_kind[ks] = 1;
                exp_data[ks] = d;
                exp_err[ks]  = pen ? ((^d) ^ pbit) : 1'b0;
            end else begin
                exp_kind[ks] = 2;
            end
        end
        drive(1'b0, de);
        for (int i = 0; i < 8; i++) begin
            drive(d[i], de);
            if (scramble && i == 1) begin
                clk_div_i   = 32'($urandom_range(0, 40));
                parity_en_i = 1'($urandom_range(0, 1));
            end
        end
        if (pen) drive(pbit, de);
        drive(stop, stop_len);
    endtask

    int n;
    int nv0;
    int nf0;

    initial begin
        rstn_i      = 1'b0;
        clk_div_i   = 32'd16;
        rx_enable_i = 1'b1;
        parity_en_i = 1'b0;
        rx_i        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rstn_i = 1'b1;
        chk("reset rx_data_o",   32'(rx_data_o),   32'h00);
        chk("reset rx_valid_o",  32'(rx_valid_o),  32'h0);
        chk("reset rx_err_o",    32'(rx_err_o),    32'h0);
        chk("reset frame_err_o", 32'(frame_err_o), 32'h0);
        drive(1'b1, 5);

        // 0xA5, no parity: pulse 155 cycles after the start bit is driven.
        nv0 = n_valid;
        send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b1, 16, 1'b1, 1'b0, n);
        chk("model pin A5", 32'(exp_kind.exists(n + 155)), 32'd1);
        drive(1'b1, 10);
        chk("A5 pulse count", 32'(n_valid - nv0), 32'd1);
        chk("A5 latency",     32'(last_v_cyc - n), 32'd155);
        chk("A5 data",        32'(last_v_data), 32'hA5);
        chk("A5 err",         32'(last_v_err),  32'h0);

        // 0x3C has even weight, so parity bit 1 is an error and 0 is clean.
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 16, 1'b1, 1'b0, n);
        drive(1'b1, 4);
        chk("3C/p1 latency", 32'(last_v_cyc - n), 32'd171);
        chk("3C/p1 err",     32'(last_v_err),     32'h1);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 16, 1'b1, 1'b0, n);
        drive(1'b1, 4);
        chk("3C/p0 data", 32'(last_v_data), 32'h3C);
        chk("3C/p0 err",  32'(last_v_err),  32'h0);

        // Short low glitch must be rejected silently.
        nv0 = n_valid;
        nf0 = n_ferr;
        clk_div_i = 32'd16;
        drive(1'b0, 3);
        drive(1'b1, 40);
        chk("glitch valid", 32'(n_valid - nv0), 32'd0);
        chk("glitch ferr",  32'(n_ferr - nf0),  32'd0);

        // Stop bit low, line held in break, then a clean byte.
        nv0 = n_valid;
        nf0 = n_ferr;
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 16, 1'b1, 1'b0, n);
        drive(1'b0, 40);
        drive(1'b1, 5);
        chk("break ferr count", 32'(n_ferr - nf0),   32'd1);
        chk("break ferr time",  32'(last_f_cyc - n), 32'd155);
        chk("break no valid",   32'(n_valid - nv0),  32'd0);
        send_frame(8'h12, 16, 1'b0, 1'b0, 1'b1, 16, 1'b1, 1'b0, n);
        drive(1'b1, 4);
        chk("after break data", 32'(last_v_data), 32'h12);

        // Divider changed mid-frame applies only to the next frame.
        nv0 = n_valid;
        fork
            send_frame(8'h00, 16, 1'b0, 1'b0, 1'b1, 16, 1'b1, 1'b0, n);
            begin
                repeat (40) @(posedge clk);
                #1 clk_div_i = 32'd8;
            end
        join
        chk("div16 data", 32'(last_v_data), 32'h00);
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1, 8, 1'b1, 1'b0, n);
        drive(1'b1, 4);
        chk("b2b count",    32'(n_valid - nv0),  32'd2);
        chk("div8 latency", 32'(last_v_cyc - n), 32'd79);
        chk("div8 data",    32'(last_v_data),    32'hFF);

        // Enable dropped mid-frame, then reset pulsed mid-frame; only 0x81 may appear.
        nv0 = n_valid;
        nf0 = n_ferr;
        fork
            send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b1, 16, 1'b0, 1'b0, n);
            begin
                repeat (60) @(posedge clk);
                #1 rx_enable_i = 1'b0;
            end
        join
        drive(1'b1, 5);
        rx_enable_i = 1'b1;
        drive(1'b1, 3);
        send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1, 16, 1'b1, 1'b0, n);
        drive(1'b1, 4);
        chk("enable abort count", 32'(n_valid - nv0), 32'd1);
        chk("enable abort data",  32'(last_v_data),   32'h81);
        drive(1'b0, 16);
        drive(1'b1, 16);
        drive(1'b0, 16);
        rstn_i = 1'b0;
        drive(1'b1, 3);
        rstn_i = 1'b1;
        drive(1'b1, 5);
        send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1, 16, 1'b1, 1'b0, n);
        drive(1'b1, 4);
        chk("reset abort count", 32'(n_valid - nv0), 32'd2);
        chk("reset abort ferr",  32'(n_ferr - nf0),  32'd0);
        chk("reset abort data",  32'(last_v_data),   32'h81);

        // Random frames: varying divider, parity, stop errors, short stops and mid-frame input noise.
        for (int f = 0; f < 40; f++) begin
            int       div;
            int       de;
            bit       pen;
            bit       pbit;
            bit       stop;
            bit [7:0] d;
            div  = $urandom_range(1, 24);
            de   = (div < 2) ? 2 : div;
            pen  = 1'($urandom_range(0, 1));
            pbit = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 7) != 0);
            d    = 8'($urandom);
            send_frame(d, div, pen, pbit, stop, $urandom_range(de / 2 + 1, de + 2), 1'b1, 1'b1, n);
            if (!stop) begin
                drive(1'b0, $urandom_range(0, 20));
                drive(1'b1, $urandom_range(1, 4));
            end else begin
                drive(1'b1, $urandom_range(0, 4));
            end
        end
        drive(1'b1, 50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
